// File: rtl/i2s_pkg.sv
// i2s_pkg: shared defaults and types for the I2S transmit path.
//   I2S_SLOT_W   - BCLK periods per channel slot
//   I2S_DATA_W   - sample width
//   sample_t     - one mono sample
//   bitcnt_t     - bit position within a two-slot frame
package i2s_pkg;

    localparam int I2S_SLOT_W   = 32;
    localparam int I2S_DATA_W   = 16;
    localparam int I2S_BITCNT_W = $clog2(2 * I2S_SLOT_W);

    typedef logic [I2S_DATA_W-1:0]   sample_t;
    typedef logic [I2S_BITCNT_W-1:0] bitcnt_t;

endpackage

// File: rtl/i2s_tx_bclk_gen.sv
// i2s_bclk_gen: divides clk into the I2S bit-clock phase and reports its
// transitions as single-cycle strobes, asserted in the cycle whose closing
// clk edge flips the phase.
//   clk  - system clock
//   rst  - synchronous active-high reset (phase low, count 0)
//   rise - phase goes 0->1 at the coming clk edge
//   fall - phase goes 1->0 at the coming clk edge
module i2s_bclk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic rise,
    output logic fall
);

    localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          phase;
    logic          tc;

    assign tc   = (cnt == CW'(BCLK_DIV - 1));
    assign rise = tc && !phase;
    assign fall = tc &&  phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (tc) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter for mono samples. Accepts samples over a
// valid/ready handshake into a one-entry buffer and sends each frame's
// sample MSB-first in both the left and right slots, one BCLK after the
// word-select edge. All pin outputs move on BCLK falling edges.
//   clk_i, rst_i      - clock, synchronous active-high reset
//   sample_i          - two's-complement sample
//   sample_valid_i    - sample_i valid
//   sample_ready_o    - holding buffer empty
//   frame_start_o     - pulse when a new frame latches
//   underrun_o        - pulse when a frame starts with an empty buffer
//   bclk_o, lrclk_o, sdata_o - I2S pins (lrclk_o: 0 = left, 1 = right)
// Build option: I2S_TX_MUTE_ON_UNDERRUN_EN sends zeros on underrun frames
// instead of repeating the last sample.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV = 4,
    parameter int SLOT_W   = I2S_SLOT_W,
    parameter int DATA_W   = I2S_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              sample_valid_i,
    output logic              sample_ready_o,
    output logic              frame_start_o,
    output logic              underrun_o,
    output logic              bclk_o,
    output logic              lrclk_o,
    output logic              sdata_o
);

    localparam int            BW       = $clog2(2 * SLOT_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(2 * SLOT_W - 1);
    localparam logic [BW-1:0] RIGHT_P0 = BW'(SLOT_W);

    logic              bclk_rise;
    logic              bclk_fall;
    logic [BW-1:0]     bit_cnt;
    logic [BW-1:0]     bit_nxt;
    logic              frame_ev;
    logic              slot_ev;
    logic              full;
    logic [DATA_W-1:0] buffer;
    logic [DATA_W-1:0] frame;
    logic [DATA_W-1:0] frame_nxt;
    logic [DATA_W-1:0] last;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] underrun_val;

    i2s_bclk_gen #(
        .BCLK_DIV(BCLK_DIV)
    ) u_bclk (
        .clk  (clk_i),
        .rst  (rst_i),
        .rise (bclk_rise),
        .fall (bclk_fall)
    );

    assign sample_ready_o = !full;

`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
    assign underrun_val = '0;
`else
    assign underrun_val = last;
`endif

    always_comb begin
        bit_nxt   = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        frame_ev  = bclk_fall && (bit_nxt == '0);
        // Each slot reloads the shifter, so left and right carry the same frame.
        slot_ev   = bclk_fall && ((bit_nxt == '0) || (bit_nxt == RIGHT_P0));
        frame_nxt = frame;
        if (frame_ev)
            frame_nxt = full ? buffer : underrun_val;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bclk_o        <= 1'b0;
            lrclk_o       <= 1'b0;
            sdata_o       <= 1'b0;
            frame_start_o <= 1'b0;
            underrun_o    <= 1'b0;
            bit_cnt       <= LAST_BIT;
            full          <= 1'b0;
            buffer        <= '0;
            frame         <= '0;
            last          <= '0;
            shreg         <= '0;
        end else begin
            frame_start_o <= frame_ev;
            underrun_o    <= frame_ev && !full;

            if (bclk_rise)
                bclk_o <= 1'b1;
            else if (bclk_fall)
                bclk_o <= 1'b0;

            if (bclk_fall) begin
                bit_cnt <= bit_nxt;
                lrclk_o <= (bit_nxt >= RIGHT_P0);
                if (slot_ev) begin
                    // Slot bit 0 is the one-BCLK I2S delay.
                    sdata_o <= 1'b0;
                    shreg   <= frame_nxt;
                end else begin
                    // Zero fill past the LSB gives the trailing zeros.
                    sdata_o <= shreg[DATA_W-1];
                    shreg   <= shreg << 1;
                end
            end

            frame <= frame_nxt;

            // A full buffer blocks accepts, so drain and accept never overlap.
            if (frame_ev && full) begin
                last <= buffer;
                full <= 1'b0;
            end else if (sample_valid_i && !full) begin
                buffer <= sample_i;
                full   <= 1'b1;
            end
        end
    end

endmodule
